// File: rtl/rtc_calendar_alarm_if.sv
// Control, load and status bundle of the RTC calendar with alarm.
// master drives the controls, slave is the RTC block.
interface rtc_calendar_alarm_if #(
  parameter int YEAR_W = 7
);
  localparam int TIME_W = 26 + YEAR_W;

  logic              en;
  logic              wr_time;
  logic [TIME_W-1:0] wdata;
  logic              alarm_wr;
  logic [25:0]       alarm_data;
  logic [4:0]        alarm_mask;
  logic              alarm_en;
  logic              irq_clr;
  logic [5:0]        o_sec;
  logic [5:0]        o_min;
  logic [4:0]        o_hour;
  logic [4:0]        o_day;
  logic [3:0]        o_month;
  logic [YEAR_W-1:0] o_year;
  logic              tick_1hz;
  logic              irq;

  modport master (
    output en, wr_time, wdata,
    output alarm_wr, alarm_data,
    output alarm_mask, alarm_en,
    output irq_clr,
    input  o_sec, o_min, o_hour,
    input  o_day, o_month, o_year,
    input  tick_1hz, irq
  );

  modport slave (
    input  en, wr_time, wdata,
    input  alarm_wr, alarm_data,
    input  alarm_mask, alarm_en,
    input  irq_clr,
    output o_sec, o_min, o_hour,
    output o_day, o_month, o_year,
    output tick_1hz, irq
  );
endinterface

// File: rtl/rtc_calendar_alarm.sv
// Real-time clock: prescaled 1 Hz tick, full calendar with leap
// years, single-edge carry chain and a maskable sticky alarm.
module rtc_calendar_alarm #(
  parameter int CLK_HZ = 100_000_000,
  parameter int YEAR_W = 7
) (
  input logic clk,
  input logic reset,
  rtc_calendar_alarm_if.slave bus
);
  localparam int TIME_W = 26 + YEAR_W;
  localparam int PW =
    (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(CLK_HZ - 1);

  logic [PW-1:0]     pre;
  logic [5:0]        sec;
  logic [5:0]        min;
  logic [4:0]        hour;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              tick_q;
  logic              irq_q;
  logic [25:0]       al_data;
  logic [4:0]        al_mask;

  logic              tick;
  logic              c_sec;
  logic              c_min;
  logic              c_hour;
  logic              c_day;
  logic              c_month;
  logic [4:0]        dim;
  logic [5:0]        n_sec;
  logic [5:0]        n_min;
  logic [4:0]        n_hour;
  logic [4:0]        n_day;
  logic [3:0]        n_month;
  logic [YEAR_W-1:0] n_year;
  logic              match;
  logic              hit;

  assign tick = bus.en && (pre == PMAX);

  always_comb begin
    dim = 5'd31;
    case (month)
      4'd4, 4'd6,
      4'd9, 4'd11: dim = 5'd30;
      4'd2: dim = (year[1:0] == 2'd0) ?
                  5'd29 : 5'd28;
      default: dim = 5'd31;
    endcase
  end

  // Whole carry chain resolves combinationally so
  // every field moves on the same edge.
  assign c_sec   = sec >= 6'd59;
  assign c_min   = c_sec && (min >= 6'd59);
  assign c_hour  = c_min && (hour >= 5'd23);
  assign c_day   = c_hour && (day >= dim);
  assign c_month = c_day && (month >= 4'd12);

  assign n_sec = c_sec ? 6'd0 : sec + 6'd1;

  assign n_min =
    !c_sec      ? min :
    c_min       ? 6'd0 : min + 6'd1;

  assign n_hour =
    !c_min      ? hour :
    c_hour      ? 5'd0 : hour + 5'd1;

  assign n_day =
    !c_hour     ? day :
    c_day       ? 5'd1 : day + 5'd1;

  assign n_month =
    !c_day      ? month :
    c_month     ? 4'd1 : month + 4'd1;

  assign n_year = c_month ?
    year + YEAR_W'(1) : year;

  assign match =
    (al_mask[0] || n_sec   == al_data[5:0])   &&
    (al_mask[1] || n_min   == al_data[11:6])  &&
    (al_mask[2] || n_hour  == al_data[16:12]) &&
    (al_mask[3] || n_day   == al_data[21:17]) &&
    (al_mask[4] || n_month == al_data[25:22]);

  assign hit = bus.alarm_en && tick && match;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      sec     <= '0;
      min     <= '0;
      hour    <= '0;
      day     <= 5'd1;
      month   <= 4'd1;
      year    <= '0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
      al_data <= '0;
      al_mask <= '0;
    end else begin
      tick_q <= 1'b0;
      if (bus.alarm_wr) begin
        al_data <= bus.alarm_data;
        al_mask <= bus.alarm_mask;
      end
      if (bus.irq_clr)
        irq_q <= 1'b0;
      if (bus.wr_time) begin
        pre   <= '0;
        sec   <= bus.wdata[5:0];
        min   <= bus.wdata[11:6];
        hour  <= bus.wdata[16:12];
        day   <= bus.wdata[21:17];
        month <= bus.wdata[25:22];
        year  <= bus.wdata[TIME_W-1:26];
      end else if (bus.en) begin
        pre <= (pre == PMAX) ?
               '0 : pre + PW'(1);
        if (tick) begin
          sec    <= n_sec;
          min    <= n_min;
          hour   <= n_hour;
          day    <= n_day;
          month  <= n_month;
          year   <= n_year;
          tick_q <= 1'b1;
        end
        // A hit wins over a same-cycle clear.
        if (hit)
          irq_q <= 1'b1;
      end
    end
  end

  assign bus.o_sec    = sec;
  assign bus.o_min    = min;
  assign bus.o_hour   = hour;
  assign bus.o_day    = day;
  assign bus.o_month  = month;
  assign bus.o_year   = year;
  assign bus.tick_1hz = tick_q;
  assign bus.irq      = irq_q;
endmodule
